// File: rtl/snow2_pkg.sv
// Shared definitions for the SNOW 2.0 linear feedback stage: GF(2^8) arithmetic,
// the alpha multiplier exponents, the controller state encoding and defaults.
package snow2_pkg;

    // GF(2^8) reduction polynomial x^8+x^7+x^5+x^3+1 (x^8 term implicit)
    localparam logic [7:0] GF_POLY = 8'hA9;

    localparam int unsigned INIT_ROUNDS_DEF = 32;

    // Exponents of beta for MUL_alpha, most significant output byte first
    localparam logic [7:0] MUL_EXP3 = 8'd23;
    localparam logic [7:0] MUL_EXP2 = 8'd245;
    localparam logic [7:0] MUL_EXP1 = 8'd48;
    localparam logic [7:0] MUL_EXP0 = 8'd239;

    // Exponents of beta for DIV_alpha, most significant output byte first
    localparam logic [7:0] DIV_EXP3 = 8'd16;
    localparam logic [7:0] DIV_EXP2 = 8'd39;
    localparam logic [7:0] DIV_EXP1 = 8'd6;
    localparam logic [7:0] DIV_EXP0 = 8'd64;

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StDiscard,
        StRun
    } state_e;

    // Shift-and-add multiply; with one constant operand this folds to an XOR network
    function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc ^= sh;
            sh = sh[7] ? ((sh << 1) ^ GF_POLY) : (sh << 1);
        end
        return acc;
    endfunction

    // beta^e with beta = x, by square-and-multiply; only used for constants
    function automatic logic [7:0] gf256_beta_pow(input logic [7:0] e);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = 8'h02;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf256_mul(r, p);
            p = gf256_mul(p, p);
        end
        return r;
    endfunction

endpackage

// File: rtl/snow2_lfsr_ctrl_if.sv
// Control, key/IV, FSM coupling and keystream signals of the SNOW 2.0 LFSR stage.
interface snow2_lfsr_ctrl_if;
    logic         start;
    logic         stop;
    logic [127:0] key;
    logic [127:0] iv;
    logic [31:0]  fsm_in1;
    logic [31:0]  fsm_in2;
    logic [31:0]  fsm_out;
    logic         fsm_clr;
    logic         busy;
    logic [31:0]  z;
    logic         z_valid;

    modport master (
        output start, stop, key, iv, fsm_out,
        input  fsm_in1, fsm_in2, fsm_clr, busy, z, z_valid
    );

    modport slave (
        input  start, stop, key, iv, fsm_out,
        output fsm_in1, fsm_in2, fsm_clr, busy, z, z_valid
    );
endinterface

// File: rtl/snow2_alpha.sv
// Combinational multiply by alpha and by alpha^-1 in GF(2^32) over GF(2^8).
module snow2_alpha
    import snow2_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] mul_o,
    output logic [31:0] div_o
);

    localparam logic [7:0] MulC3 = gf256_beta_pow(MUL_EXP3);
    localparam logic [7:0] MulC2 = gf256_beta_pow(MUL_EXP2);
    localparam logic [7:0] MulC1 = gf256_beta_pow(MUL_EXP1);
    localparam logic [7:0] MulC0 = gf256_beta_pow(MUL_EXP0);
    localparam logic [7:0] DivC3 = gf256_beta_pow(DIV_EXP3);
    localparam logic [7:0] DivC2 = gf256_beta_pow(DIV_EXP2);
    localparam logic [7:0] DivC1 = gf256_beta_pow(DIV_EXP1);
    localparam logic [7:0] DivC0 = gf256_beta_pow(DIV_EXP0);

    logic [7:0] ca;
    logic [7:0] cb;

    assign ca = a_i[31:24];
    assign cb = b_i[7:0];

    // Byte shift plus the constant-coefficient correction from the byte shifted out
    always_comb begin
        mul_o = {a_i[23:0], 8'h00} ^ {gf256_mul(ca, MulC3), gf256_mul(ca, MulC2),
                                      gf256_mul(ca, MulC1), gf256_mul(ca, MulC0)};
        div_o = {8'h00, b_i[31:8]} ^ {gf256_mul(cb, DivC3), gf256_mul(cb, DivC2),
                                      gf256_mul(cb, DivC1), gf256_mul(cb, DivC0)};
    end

endmodule

// File: rtl/snow2_lfsr_ctrl.sv
// SNOW 2.0 LFSR stage: key/IV load, initialisation clocks with FSM feedback,
// one discard clock, then one registered keystream word per clock.
module snow2_lfsr_ctrl
    import snow2_pkg::*;
#(
    parameter int unsigned INIT_ROUNDS = INIT_ROUNDS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    snow2_lfsr_ctrl_if.slave    bus
);

    localparam int unsigned        CntW    = $clog2(INIT_ROUNDS + 1);
    localparam logic [CntW-1:0]    LastCnt = CntW'(INIT_ROUNDS - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     s_q [16];
    logic [31:0]     s_d [16];
    logic [31:0]     z_q, z_d;
    logic            z_valid_q, z_valid_d;

    logic [31:0] k3, k2, k1, k0, iv3, iv2, iv1, iv0;
    logic [31:0] alpha_s0, alphainv_s11, fb;
    logic        shift_en, init_mode;

    assign {k3, k2, k1, k0}     = bus.key;
    assign {iv3, iv2, iv1, iv0} = bus.iv;

    snow2_alpha u_alpha (
        .a_i   (s_q[0]),
        .b_i   (s_q[11]),
        .mul_o (alpha_s0),
        .div_o (alphainv_s11)
    );

    assign fb = alpha_s0 ^ s_q[2] ^ alphainv_s11;

    // Next-state: control sequencing, key/IV load and LFSR clocking
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        z_d       = z_q;
        z_valid_d = z_valid_q;
        shift_en  = 1'b0;
        init_mode = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    s_d[15] = k3 ^ iv0;
                    s_d[14] = k2;
                    s_d[13] = k1;
                    s_d[12] = k0 ^ iv1;
                    s_d[11] = ~k3;
                    s_d[10] = ~k2 ^ iv2;
                    s_d[9]  = ~k1 ^ iv3;
                    s_d[8]  = ~k0;
                    s_d[7]  = k3;
                    s_d[6]  = k2;
                    s_d[5]  = k1;
                    s_d[4]  = k0;
                    s_d[3]  = ~k3;
                    s_d[2]  = ~k2;
                    s_d[1]  = ~k1;
                    s_d[0]  = ~k0;
                    cnt_d   = '0;
                    state_d = StInit;
                end
            end
            StInit: begin
                shift_en  = 1'b1;
                init_mode = 1'b1;
                cnt_d     = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) state_d = StDiscard;
            end
            StDiscard: begin
                shift_en = 1'b1;
                state_d  = StRun;
            end
            StRun: begin
                shift_en  = 1'b1;
                z_d       = bus.fsm_out ^ s_q[0];
                z_valid_d = 1'b1;
                // The stop edge still clocks the LFSR but presents no word
                if (bus.stop) begin
                    z_valid_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (shift_en) begin
            for (int i = 0; i < 15; i++) s_d[i] = s_q[i+1];
            s_d[15] = fb ^ (init_mode ? bus.fsm_out : 32'h0);
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            z_q       <= '0;
            z_valid_q <= 1'b0;
            for (int i = 0; i < 16; i++) s_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            z_q       <= z_d;
            z_valid_q <= z_valid_d;
            s_q       <= s_d;
        end
    end

    assign bus.fsm_in1 = s_q[15];
    assign bus.fsm_in2 = s_q[5];
    assign bus.z       = z_q;
    assign bus.z_valid = z_valid_q;
    assign bus.busy    = (state_q == StInit) || (state_q == StDiscard);
    assign bus.fsm_clr = (state_q == StIdle) && bus.start && !rst;

endmodule

// File: tb/tb_snow2_lfsr_ctrl.sv
// Bench for snow2_lfsr_ctrl: supplies a SNOW 2.0 FSM, checks alpha arithmetic from a
// table, and checks keystream, latency and control corner cases against a software model.
module tb_snow2_lfsr_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snow2_lfsr_ctrl_if bus ();

    snow2_lfsr_ctrl #(.INIT_ROUNDS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] ax, am1, bd1, am2, bd2;
    snow2_alpha u_alpha1 (.a_i(ax),  .b_i(ax),  .mul_o(am1), .div_o(bd1));
    snow2_alpha u_alpha2 (.a_i(bd1), .b_i(am1), .mul_o(am2), .div_o(bd2));

    int errors = 0;
    int checks = 0;

    // ---------------- GF(2^8) poly 0xA9 via exp/log tables ----------------
    logic [7:0] gexp [0:254];
    int         glog [0:255];

    function automatic logic [7:0] xt_a9(input logic [7:0] v);
        return v[7] ? ((v << 1) ^ 8'hA9) : (v << 1);
    endfunction

    task automatic init_gf();
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = v;
            glog[v] = i;
            v = xt_a9(v);
        end
    endtask

    function automatic logic [7:0] gmx(input logic [7:0] c, input int e);
        if (c == 8'h00) return 8'h00;
        return gexp[(glog[c] + e) % 255];
    endfunction

    function automatic logic [31:0] m_alpha(input logic [31:0] x);
        logic [7:0] c;
        c = x[31:24];
        return {x[23:0], 8'h00} ^ {gmx(c, 23), gmx(c, 245), gmx(c, 48), gmx(c, 239)};
    endfunction

    function automatic logic [31:0] m_alinv(input logic [31:0] x);
        logic [7:0] c;
        c = x[7:0];
        return {8'h00, x[31:8]} ^ {gmx(c, 16), gmx(c, 39), gmx(c, 6), gmx(c, 64)};
    endfunction

    // ---------------- AES-based S-box of the SNOW 2.0 FSM ----------------
    function automatic logic [7:0] aes_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc, sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc ^= sh;
            sh = sh[7] ? ((sh << 1) ^ 8'h1B) : (sh << 1);
        end
        return acc;
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] t, r;
        t = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t = aes_mul(t, t);
            r = aes_mul(r, t);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [31:0] snow_s(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3, r0, r1, r2, r3;
        a0 = aes_sbox(w[7:0]);
        a1 = aes_sbox(w[15:8]);
        a2 = aes_sbox(w[23:16]);
        a3 = aes_sbox(w[31:24]);
        r0 = aes_mul(a0, 8'h02) ^ aes_mul(a1, 8'h03) ^ a2 ^ a3;
        r1 = a0 ^ aes_mul(a1, 8'h02) ^ aes_mul(a2, 8'h03) ^ a3;
        r2 = a0 ^ a1 ^ aes_mul(a2, 8'h02) ^ aes_mul(a3, 8'h03);
        r3 = aes_mul(a0, 8'h03) ^ a1 ^ a2 ^ aes_mul(a3, 8'h02);
        return {r3, r2, r1, r0};
    endfunction

    // ---------------- FSM attached to the DUT ----------------
    logic [31:0] r1_q, r2_q;
    always @(posedge clk or posedge rst) begin
        if (rst || bus.fsm_clr) begin
            r1_q <= 32'h0;
            r2_q <= 32'h0;
        end else begin
            r1_q <= r2_q + bus.fsm_in2;
            r2_q <= snow_s(r1_q);
        end
    end
    assign bus.fsm_out = (bus.fsm_in1 + r1_q) ^ r2_q;

    // ---------------- full cipher reference model ----------------
    logic [31:0] mz [0:15];
    logic [31:0] ms15, ms5;

    task automatic model_ks(input logic [127:0] k, input logic [127:0] v, input int nrun);
        logic [31:0] s [16];
        logic [31:0] k3, k2, k1, k0, v3, v2, v1, v0, r1, r2, f, fb, nr1, nr2;
        {k3, k2, k1, k0} = k;
        {v3, v2, v1, v0} = v;
        s[15] = k3 ^ v0;  s[14] = k2;       s[13] = k1;       s[12] = k0 ^ v1;
        s[11] = ~k3;      s[10] = ~k2 ^ v2; s[9]  = ~k1 ^ v3; s[8]  = ~k0;
        s[7]  = k3;       s[6]  = k2;       s[5]  = k1;       s[4]  = k0;
        s[3]  = ~k3;      s[2]  = ~k2;      s[1]  = ~k1;      s[0]  = ~k0;
        r1 = 32'h0;
        r2 = 32'h0;
        for (int step = 0; step < 33 + nrun; step++) begin
            f = (s[15] + r1) ^ r2;
            if (step >= 33) mz[step-33] = f ^ s[0];
            fb = m_alpha(s[0]) ^ s[2] ^ m_alinv(s[11]);
            if (step < 32) fb ^= f;
            nr1 = r2 + s[5];
            nr2 = snow_s(r1);
            for (int i = 0; i < 15; i++) s[i] = s[i+1];
            s[15] = fb;
            r1 = nr1;
            r2 = nr2;
        end
        ms15 = s[15];
        ms5  = s[5];
    endtask

    // ---------------- check helpers ----------------
    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge (E0); returns just after E0
    task automatic do_start();
        bus.start = 1'b1;
        #1;
        chk_int("fsm_clr with start in idle", int'(bus.fsm_clr), 1);
        tick();
        bus.start = 1'b0;
    endtask

    // From edge index idx0, wait (bounded) for the first valid word
    task automatic wait_valid(input int idx0, input int exp_busy, input string tag);
        int idx;
        int nbusy;
        idx   = idx0;
        nbusy = int'(bus.busy);
        while (!bus.z_valid && idx < idx0 + 60) begin
            tick();
            idx++;
            nbusy += int'(bus.busy);
        end
        chk_int({tag, " first z_valid edge"}, idx, 34);
        chk_int({tag, " busy cycles"}, nbusy, exp_busy);
    endtask

    task automatic check_words(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            if (i > lo) tick();
            chk_int($sformatf("%s z_valid word %0d", tag, i), int'(bus.z_valid), 1);
            chk32($sformatf("%s z word %0d", tag, i), bus.z, mz[i]);
        end
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] exp_mul;
        logic [31:0] exp_div;
    } alpha_vec_t;

    alpha_vec_t avec [6];

    localparam logic [127:0] KeyKat = 128'h80000000_00000000_00000000_00000000;
    localparam logic [127:0] Key2   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] Iv2    = 128'h00000001_00000002_00000003_00000004;
    localparam logic [127:0] Key3   = 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        init_gf();
        avec[0] = '{32'h00000000, 32'h00000000, 32'h00000000};
        avec[1] = '{32'h00ABCD00, 32'hABCD0000, 32'h0000ABCD};
        avec[2] = '{32'h00000100, 32'h00010000, 32'h00000001};
        avec[3] = '{32'h00FFFF00, 32'hFFFF0000, 32'h0000FFFF};
        avec[4] = '{32'h00000001, 32'h00000100, m_alinv(32'h00000001)};
        avec[5] = '{32'h12345678, m_alpha(32'h12345678), m_alinv(32'h12345678)};

        // Reset state, with start held to show fsm_clr is masked by reset
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.stop  = 1'b0;
        bus.key   = '0;
        bus.iv    = '0;
        ax        = '0;
        repeat (2) tick();
        chk_int("reset fsm_clr", int'(bus.fsm_clr), 0);
        chk_int("reset z_valid", int'(bus.z_valid), 0);
        chk_int("reset busy", int'(bus.busy), 0);
        chk32("reset z", bus.z, 32'h0);
        chk32("reset fsm_in1", bus.fsm_in1, 32'h0);
        chk32("reset fsm_in2", bus.fsm_in2, 32'h0);
        bus.start = 1'b0;
        rst       = 1'b0;
        tick();

        // Alpha unit table
        for (int i = 0; i < 6; i++) begin
            ax = avec[i].x;
            #1;
            chk32($sformatf("alpha mul row %0d", i), am1, avec[i].exp_mul);
            chk32($sformatf("alpha div row %0d", i), bd1, avec[i].exp_div);
            chk32($sformatf("alpha mul(div) row %0d", i), am2, avec[i].x);
            chk32($sformatf("alpha div(mul) row %0d", i), bd2, avec[i].x);
        end

        // Known answer, latency and busy length
        bus.key = KeyKat;
        bus.iv  = '0;
        model_ks(KeyKat, 128'h0, 9);
        do_start();
        wait_valid(0, 33, "kat");
        chk32("kat word 0 constant", bus.z, 32'h8D590AE9);
        check_words(0, 1, "kat");
        chk32("kat word 1 constant", bus.z, 32'hA74A7D05);
        tick();
        check_words(2, 7, "kat");

        // Stop on the 9th run edge: idle, flags low, LFSR frozen
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk_int("stop z_valid", int'(bus.z_valid), 0);
        chk_int("stop busy", int'(bus.busy), 0);
        chk32("stop fsm_in1", bus.fsm_in1, ms15);
        chk32("stop fsm_in2", bus.fsm_in2, ms5);
        repeat (3) tick();
        chk32("idle frozen fsm_in1", bus.fsm_in1, ms15);
        chk32("idle frozen fsm_in2", bus.fsm_in2, ms5);
        chk_int("idle z_valid", int'(bus.z_valid), 0);
        do_start();
        wait_valid(0, 33, "restart");
        chk32("restart word 0 constant", bus.z, 32'h8D590AE9);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;

        // Reset after E10 of an init sequence, then a clean run
        bus.key = Key2;
        bus.iv  = Iv2;
        model_ks(Key2, Iv2, 8);
        do_start();
        repeat (10) tick();
        rst = 1'b1;
        #1;
        chk32("mid-init reset z", bus.z, 32'h0);
        chk_int("mid-init reset z_valid", int'(bus.z_valid), 0);
        chk_int("mid-init reset busy", int'(bus.busy), 0);
        chk32("mid-init reset fsm_in1", bus.fsm_in1, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        do_start();
        wait_valid(0, 33, "post-reset");
        check_words(0, 7, "post-reset");
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;

        // start (with a different key) during INIT and RUN, stop during INIT: all ignored
        do_start();
        repeat (5) tick();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        bus.key   = Key3;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        wait_valid(6, 27, "start-in-init");
        check_words(0, 3, "ignored start");
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_words(4, 7, "ignored start");
        bus.key  = Key2;
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk_int("final stop z_valid", int'(bus.z_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
